// File: rtl/accel_avg_filter_if.sv
// Bundle of the moving-average filter's sample, window and result signals.
// Latency: none; this is wiring only, the filter adds one registered cycle.
// Backpressure: none; the producer may assert in_valid every cycle.
interface accel_avg_filter_if #(
    parameter int CHANNELS  = 3,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 10
);
    logic [2:0]                    window_log2;
    logic                          in_valid;
    logic [CHANNELS*IN_WIDTH-1:0]  in_data;
    logic                          out_valid;
    logic [CHANNELS*OUT_WIDTH-1:0] out_data;
    logic                          warm;

    // Sampler side: drives samples and the requested window.
    modport master (
        output window_log2, in_valid, in_data,
        input  out_valid, out_data, warm
    );

    // Filter side.
    modport slave (
        input  window_log2, in_valid, in_data,
        output out_valid, out_data, warm
    );
endinterface

// File: rtl/accel_avg_filter.sv
// Multi-channel moving average over a runtime 2^k window with warm-up and flush.
// Latency: one cycle from an accepted sample to its out_valid pulse.
// Backpressure: none; accepts a sample every cycle at full rate.
module accel_avg_filter #(
    parameter int CHANNELS  = 3,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 10,
    parameter int MAX_LOG2  = 4,
    parameter bit SATURATE  = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    accel_avg_filter_if.slave bus
);
    localparam int DEPTH = 1 << MAX_LOG2;
    localparam int KW    = $clog2(MAX_LOG2 + 1);
    localparam int FW    = MAX_LOG2 + 1;
    localparam int SW    = IN_WIDTH + MAX_LOG2;
    localparam int AW    = (SW > OUT_WIDTH) ? SW : OUT_WIDTH;

    logic [KW-1:0]       kc;
    logic [KW-1:0]       k_act;
    logic [FW-1:0]       win;
    logic [FW-1:0]       fill;
    logic [FW-1:0]       fill_nx;
    logic [MAX_LOG2-1:0] wp;
    logic [MAX_LOG2-1:0] rd_ptr;
    logic                change;
    logic                accept;
    logic                full;
    logic                out_fire;

    logic [IN_WIDTH-1:0]  x       [CHANNELS];
    logic [SW-1:0]        sum_q   [CHANNELS];
    logic [SW-1:0]        sum_nx  [CHANNELS];
    logic [AW-1:0]        avg     [CHANNELS];
    logic [OUT_WIDTH-1:0] res     [CHANNELS];
    logic [IN_WIDTH-1:0]  hist    [CHANNELS][DEPTH];

    logic [CHANNELS*OUT_WIDTH-1:0] res_packed;
    logic [CHANNELS*OUT_WIDTH-1:0] out_data_q;
    logic                          out_valid_q;
    logic                          warm_q;

    // Clamp the requested exponent and derive window control decisions.
    always_comb begin
        kc = KW'(bus.window_log2);
        if (int'(bus.window_log2) > MAX_LOG2) begin
            kc = KW'(MAX_LOG2);
        end
        win      = FW'(1) << k_act;
        change   = (kc != k_act);
        accept   = bus.in_valid && !change;
        full     = (fill == win);
        fill_nx  = full ? fill : fill + FW'(1);
        out_fire = accept && (fill_nx == win);
        // Oldest sample of the window; when W equals the depth this is the
        // slot about to be overwritten, whose old contents are still readable.
        rd_ptr   = wp - win[MAX_LOG2-1:0];
    end

    // Per-channel running-sum update, divide by shift, optional clamp.
    always_comb begin
        res_packed = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            x[c]      = bus.in_data[c*IN_WIDTH +: IN_WIDTH];
            sum_nx[c] = sum_q[c] + SW'(x[c]);
            if (full) begin
                sum_nx[c] = sum_nx[c] - SW'(hist[c][rd_ptr]);
            end
            avg[c] = AW'(sum_nx[c]) >> k_act;
            res[c] = avg[c][OUT_WIDTH-1:0];
            if (SATURATE && ((avg[c] >> OUT_WIDTH) != '0)) begin
                res[c] = '1;
            end
            res_packed[c*OUT_WIDTH +: OUT_WIDTH] = res[c];
        end
    end

    // Window register, sums, fill, write pointer and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k_act       <= kc;
            fill        <= '0;
            wp          <= '0;
            warm_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c] <= '0;
            end
        end else begin
            out_valid_q <= out_fire;
            if (change) begin
                // Flush; a coincident sample seeds the new window.
                k_act  <= kc;
                warm_q <= 1'b0;
                fill   <= bus.in_valid ? FW'(1) : FW'(0);
                if (bus.in_valid) begin
                    wp <= wp + 1'b1;
                end
                for (int c = 0; c < CHANNELS; c++) begin
                    sum_q[c] <= bus.in_valid ? SW'(x[c]) : '0;
                end
            end else if (bus.in_valid) begin
                fill <= fill_nx;
                wp   <= wp + 1'b1;
                for (int c = 0; c < CHANNELS; c++) begin
                    sum_q[c] <= sum_nx[c];
                end
                if (out_fire) begin
                    warm_q     <= 1'b1;
                    out_data_q <= res_packed;
                end
            end
        end
    end

    // History buffer; never read before written, so it carries no reset.
    always_ff @(posedge clock) begin
        if (bus.in_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
                hist[c][wp] <= x[c];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.warm      = warm_q;
endmodule

// File: tb/tb_accel_avg_filter.sv
// Bench for accel_avg_filter: vector table plus scoreboard-checked sequences.
// Latency: expects out_valid one cycle after the W-th accepted sample.
// Backpressure: none exercised; samples are driven back to back.
module tb_accel_avg_filter;
    logic clock;
    logic reset_n;

    accel_avg_filter_if #(.CHANNELS(3), .IN_WIDTH(16), .OUT_WIDTH(10)) bus_s ();
    accel_avg_filter_if #(.CHANNELS(3), .IN_WIDTH(16), .OUT_WIDTH(10)) bus_t ();

    accel_avg_filter #(.CHANNELS(3), .IN_WIDTH(16), .OUT_WIDTH(10), .MAX_LOG2(4), .SATURATE(1'b1))
        u_dut (.clock(clock), .reset_n(reset_n), .bus(bus_s.slave));
    accel_avg_filter #(.CHANNELS(3), .IN_WIDTH(16), .OUT_WIDTH(10), .MAX_LOG2(4), .SATURATE(1'b0))
        u_dut_trunc (.clock(clock), .reset_n(reset_n), .bus(bus_t.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [29:0] sat;
        logic [29:0] trunc;
    } exp_t;

    typedef struct {
        logic        v;
        logic [2:0]  w;
        logic [15:0] d0, d1, d2;
        logic        ev;
        logic [9:0]  e0, e1, e2;
        logic        ew;
    } vec_t;

    exp_t        sb[$];
    logic [47:0] hist[$];
    int          km;
    logic        warm_m;
    logic        exp_vld;
    logic [2:0]  w_cur;
    int          errors;
    int          checks;
    vec_t        tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: keeps the raw samples since the last flush and averages the last W.
    task automatic model_step(input logic v, input logic [2:0] w, input logic [47:0] d);
        int          kc;
        int          wn;
        int          s;
        int          a;
        logic [47:0] h;
        exp_t        e;
        kc = (int'(w) > 4) ? 4 : int'(w);
        exp_vld = 1'b0;
        if (kc != km) begin
            km = kc;
            hist.delete();
            warm_m = 1'b0;
            if (v) hist.push_back(d);
        end else if (v) begin
            hist.push_back(d);
            wn = 1 << km;
            if (hist.size() > wn) void'(hist.pop_front());
            if (hist.size() == wn) begin
                e.sat   = '0;
                e.trunc = '0;
                for (int c = 0; c < 3; c++) begin
                    s = 0;
                    for (int i = 0; i < hist.size(); i++) begin
                        h = hist[i];
                        s += int'(h[c*16 +: 16]);
                    end
                    a = s >> km;
                    e.sat[c*10 +: 10]   = (a > 1023) ? 10'd1023 : 10'(a);
                    e.trunc[c*10 +: 10] = 10'(a % 1024);
                end
                sb.push_back(e);
                exp_vld = 1'b1;
                warm_m  = 1'b1;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        chk("out_valid", 64'(bus_s.out_valid), 64'(exp_vld));
        chk("out_valid_trunc", 64'(bus_t.out_valid), 64'(exp_vld));
        chk("warm", 64'(bus_s.warm), 64'(warm_m));
        if (bus_s.out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pulse", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_out_data_sat", 64'(bus_s.out_data), 64'(e.sat));
                chk("sb_out_data_trunc", 64'(bus_t.out_data), 64'(e.trunc));
            end
        end else if (sb.size() != 0) begin
            void'(sb.pop_front());
        end
    endtask

    // One clock: drive at the falling edge, accept at the rising edge, check at the next fall.
    task automatic cycle(input logic v, input logic [2:0] w, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] c);
        logic [47:0] d;
        d = {c, b, a};
        bus_s.in_valid = v;  bus_s.window_log2 = w;  bus_s.in_data = d;
        bus_t.in_valid = v;  bus_t.window_log2 = w;  bus_t.in_data = d;
        w_cur = w;
        model_step(v, w, d);
        @(posedge clock);
        @(negedge clock);
        monitor();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        km     = 0;
        warm_m = 1'b0;
        w_cur  = 3'd0;
        reset_n = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.window_log2 = 3'd0; bus_s.in_data = '0;
        bus_t.in_valid = 1'b0; bus_t.window_log2 = 3'd0; bus_t.in_data = '0;

        tbl[0] = '{1'b1, 3'd0, 16'd300,  16'd5, 16'd1023, 1'b1, 10'd300,  10'd5, 10'd1023, 1'b1};
        tbl[1] = '{1'b0, 3'd0, 16'd0,    16'd0, 16'd0,    1'b0, 10'd300,  10'd5, 10'd1023, 1'b1};
        tbl[2] = '{1'b1, 3'd0, 16'd2000, 16'd0, 16'd7,    1'b1, 10'd1023, 10'd0, 10'd7,    1'b1};
        tbl[3] = '{1'b0, 3'd2, 16'd0,    16'd0, 16'd0,    1'b0, 10'd1023, 10'd0, 10'd7,    1'b0};
        tbl[4] = '{1'b1, 3'd2, 16'd10,   16'd4, 16'd0,    1'b0, 10'd1023, 10'd0, 10'd7,    1'b0};
        tbl[5] = '{1'b1, 3'd2, 16'd20,   16'd4, 16'd0,    1'b0, 10'd1023, 10'd0, 10'd7,    1'b0};
        tbl[6] = '{1'b1, 3'd2, 16'd30,   16'd4, 16'd0,    1'b0, 10'd1023, 10'd0, 10'd7,    1'b0};
        tbl[7] = '{1'b1, 3'd2, 16'd40,   16'd4, 16'd0,    1'b1, 10'd25,   10'd4, 10'd0,    1'b1};
        tbl[8] = '{1'b1, 3'd2, 16'd50,   16'd8, 16'd0,    1'b1, 10'd35,   10'd5, 10'd0,    1'b1};

        // Reset state, observed while reset is held.
        #12;
        chk("rst_out_valid", 64'(bus_s.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus_s.out_data), 64'(0));
        chk("rst_warm", 64'(bus_s.warm), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        // W=1 pass-through, saturation, then a window change and W=4 warm-up.
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].w, tbl[i].d0, tbl[i].d1, tbl[i].d2);
            chk($sformatf("tbl%0d_out_valid", i), 64'(bus_s.out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_out_data", i), 64'(bus_s.out_data),
                64'({tbl[i].e2, tbl[i].e1, tbl[i].e0}));
            chk($sformatf("tbl%0d_warm", i), 64'(bus_s.warm), 64'(tbl[i].ew));
        end

        // W=16 step response; the change coincides with the first sample.
        for (int i = 0; i < 16; i++) cycle(1'b1, 3'd4, 16'd1000, 16'd0, 16'd0);
        chk("w16_first_out", 64'(bus_s.out_data[9:0]), 64'(1000));
        for (int i = 0; i < 16; i++) cycle(1'b1, 3'd4, 16'd0, 16'd0, 16'd0);
        chk("w16_last_out", 64'(bus_s.out_data[9:0]), 64'(0));

        // W=2 with sum above output range: clamp versus truncation.
        cycle(1'b0, 3'd1, 16'd0, 16'd0, 16'd0);
        cycle(1'b1, 3'd1, 16'd2000, 16'd0, 16'd0);
        cycle(1'b1, 3'd1, 16'd2000, 16'd0, 16'd0);
        chk("sat_clamp", 64'(bus_s.out_data[9:0]), 64'(1023));
        chk("trunc_wrap", 64'(bus_t.out_data[9:0]), 64'(976));

        // Warm at W=4, flush to W=8 on a sample cycle, then oversized exponent.
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd2, 16'd100, 16'd0, 16'd0);
        chk("w4_warm", 64'(bus_s.warm), 64'(1));
        cycle(1'b1, 3'd3, 16'd8, 16'd0, 16'd0);
        chk("flush_warm", 64'(bus_s.warm), 64'(0));
        chk("flush_no_valid", 64'(bus_s.out_valid), 64'(0));
        chk("flush_hold", 64'(bus_s.out_data[9:0]), 64'(100));
        for (int i = 0; i < 7; i++) cycle(1'b1, 3'd3, 16'd8, 16'd0, 16'd0);
        chk("w8_valid", 64'(bus_s.out_valid), 64'(1));
        chk("w8_out", 64'(bus_s.out_data[9:0]), 64'(8));
        for (int i = 0; i < 16; i++) cycle(1'b1, 3'd7, 16'd48, 16'd3, 16'd0);
        chk("w_clamp_valid", 64'(bus_s.out_valid), 64'(1));
        chk("w_clamp_out", 64'(bus_s.out_data[9:0]), 64'(48));

        // Asynchronous reset between edges, then a full refill.
        #2;
        reset_n = 1'b0;
        bus_s.in_valid = 1'b0;
        bus_t.in_valid = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus_s.out_valid), 64'(0));
        chk("arst_out_data", 64'(bus_s.out_data), 64'(0));
        chk("arst_warm", 64'(bus_s.warm), 64'(0));
        sb.delete();
        hist.delete();
        warm_m = 1'b0;
        km = (int'(w_cur) > 4) ? 4 : int'(w_cur);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) cycle(1'b1, 3'd7, 16'd200, 16'd0, 16'd0);
        chk("refill_out", 64'(bus_s.out_data[9:0]), 64'(200));
        chk("sb_drain", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
